// File: rtl/affine2_pkg.sv
// Shared constants and state encoding for the affine2 second stage.
// Word/sum widths and the fixed post-sum scaling shift live here so the
// adder and its sequencer always agree on the arithmetic.
package affine2_pkg;

  localparam int A2_WORD_W = 9;
  localparam int A2_FANIN  = 32;
  localparam int A2_SUM_W  = 14;
  localparam int A2_SHIFT  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SUM  = 2'd2,
    ST_OUT  = 2'd3
  } a2_state_e;

endpackage

// File: rtl/affine2_op2.sv
// Second-stage adder: sums 32 unsigned 9-bit words into a 14-bit total.
// Latency: purely combinational; output is sum[11:3] (divide by 8, wrap mod 512).
// Backpressure: none, the caller captures data_out when it needs it.
module affine2_op2
  import affine2_pkg::*;
(
  input  logic [A2_WORD_W-1:0] data0_in,  input  logic [A2_WORD_W-1:0] data1_in,
  input  logic [A2_WORD_W-1:0] data2_in,  input  logic [A2_WORD_W-1:0] data3_in,
  input  logic [A2_WORD_W-1:0] data4_in,  input  logic [A2_WORD_W-1:0] data5_in,
  input  logic [A2_WORD_W-1:0] data6_in,  input  logic [A2_WORD_W-1:0] data7_in,
  input  logic [A2_WORD_W-1:0] data8_in,  input  logic [A2_WORD_W-1:0] data9_in,
  input  logic [A2_WORD_W-1:0] data10_in, input  logic [A2_WORD_W-1:0] data11_in,
  input  logic [A2_WORD_W-1:0] data12_in, input  logic [A2_WORD_W-1:0] data13_in,
  input  logic [A2_WORD_W-1:0] data14_in, input  logic [A2_WORD_W-1:0] data15_in,
  input  logic [A2_WORD_W-1:0] data16_in, input  logic [A2_WORD_W-1:0] data17_in,
  input  logic [A2_WORD_W-1:0] data18_in, input  logic [A2_WORD_W-1:0] data19_in,
  input  logic [A2_WORD_W-1:0] data20_in, input  logic [A2_WORD_W-1:0] data21_in,
  input  logic [A2_WORD_W-1:0] data22_in, input  logic [A2_WORD_W-1:0] data23_in,
  input  logic [A2_WORD_W-1:0] data24_in, input  logic [A2_WORD_W-1:0] data25_in,
  input  logic [A2_WORD_W-1:0] data26_in, input  logic [A2_WORD_W-1:0] data27_in,
  input  logic [A2_WORD_W-1:0] data28_in, input  logic [A2_WORD_W-1:0] data29_in,
  input  logic [A2_WORD_W-1:0] data30_in, input  logic [A2_WORD_W-1:0] data31_in,
  output logic [A2_WORD_W-1:0] data_out
);

  logic [A2_WORD_W-1:0] words [A2_FANIN];
  logic [A2_SUM_W-1:0]  sum;
  logic                 unused_sum_bits;

  assign words = '{data0_in,  data1_in,  data2_in,  data3_in,  data4_in,  data5_in,
                   data6_in,  data7_in,  data8_in,  data9_in,  data10_in, data11_in,
                   data12_in, data13_in, data14_in, data15_in, data16_in, data17_in,
                   data18_in, data19_in, data20_in, data21_in, data22_in, data23_in,
                   data24_in, data25_in, data26_in, data27_in, data28_in, data29_in,
                   data30_in, data31_in};

  // Full-width sum of all 32 words; 14 bits cannot overflow (32 * 511 = 16352).
  always_comb begin
    sum = '0;
    for (int i = 0; i < A2_FANIN; i++) begin
      sum = sum + A2_SUM_W'(words[i]);
    end
  end

  // Scale by 1/8 and keep the low 9 bits; bits above 11 are dropped (wrap, no saturation).
  assign data_out        = sum[A2_SHIFT +: A2_WORD_W];
  assign unused_sum_bits = ^{sum[A2_SUM_W-1:A2_SHIFT+A2_WORD_W], sum[A2_SHIFT-1:0]};

endmodule

// File: rtl/affine2_seq.sv
// Sequencer: gathers 32 streamed words per neuron, fires the adder once, emits N_OUT results.
// Latency: 32 load cycles + 1 sum cycle, result valid from the following cycle.
// Backpressure: in_ready only in LOAD; result held in OUT until out_ready, no word consumed meanwhile.
module affine2_seq
  import affine2_pkg::*;
#(
  parameter int N_OUT = 10
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A2_WORD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A2_WORD_W-1:0] out_data,
  output logic [3:0]           out_index,
  output logic                 out_last
);

  localparam logic [3:0] LAST_IDX = 4'(N_OUT - 1);

  a2_state_e            state_q;
  logic [4:0]           widx_q;
  logic [3:0]           nidx_q;
  logic [A2_WORD_W-1:0] bank_q [A2_FANIN];
  logic [A2_WORD_W-1:0] out_data_q;
  logic [3:0]           out_index_q;
  logic                 done_q;
  logic [A2_WORD_W-1:0] sum_d;

  affine2_op2 op2 (
    .data0_in (bank_q[0]),  .data1_in (bank_q[1]),  .data2_in (bank_q[2]),  .data3_in (bank_q[3]),
    .data4_in (bank_q[4]),  .data5_in (bank_q[5]),  .data6_in (bank_q[6]),  .data7_in (bank_q[7]),
    .data8_in (bank_q[8]),  .data9_in (bank_q[9]),  .data10_in(bank_q[10]), .data11_in(bank_q[11]),
    .data12_in(bank_q[12]), .data13_in(bank_q[13]), .data14_in(bank_q[14]), .data15_in(bank_q[15]),
    .data16_in(bank_q[16]), .data17_in(bank_q[17]), .data18_in(bank_q[18]), .data19_in(bank_q[19]),
    .data20_in(bank_q[20]), .data21_in(bank_q[21]), .data22_in(bank_q[22]), .data23_in(bank_q[23]),
    .data24_in(bank_q[24]), .data25_in(bank_q[25]), .data26_in(bank_q[26]), .data27_in(bank_q[27]),
    .data28_in(bank_q[28]), .data29_in(bank_q[29]), .data30_in(bank_q[30]), .data31_in(bank_q[31]),
    .data_out (sum_d)
  );

  // Frame FSM: owns the bank, both counters, the captured result and the done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      widx_q      <= '0;
      nidx_q      <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
      for (int i = 0; i < A2_FANIN; i++) begin
        bank_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          widx_q <= '0;
          nidx_q <= '0;
          if (start) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (in_valid) begin
            bank_q[widx_q] <= in_data;
            // 5-bit counter wraps 31 -> 0 on the final word of the bank.
            widx_q <= widx_q + 5'd1;
            if (widx_q == 5'd31) state_q <= ST_SUM;
          end
        end
        ST_SUM: begin
          out_data_q  <= sum_d;
          out_index_q <= nidx_q;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            if (nidx_q == LAST_IDX) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
            end else begin
              nidx_q  <= nidx_q + 4'd1;
              state_q <= ST_LOAD;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Handshake outputs decode only registered state, so no input-to-output combinational path.
  assign busy      = (state_q != ST_IDLE);
  assign in_ready  = (state_q == ST_LOAD);
  assign out_valid = (state_q == ST_OUT);
  assign out_last  = out_valid && (out_index_q == LAST_IDX);
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign done      = done_q;

endmodule

// File: tb/tb_affine2_seq.sv
// Directed bench for affine2_seq: a one-neuron instance and a three-neuron instance share stimulus.
module tb_affine2_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sel = 1'b1;            // 1: drive/observe the N_OUT=1 instance, 0: the N_OUT=3 instance
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] in_data = '0;
  logic       out_ready = 1'b0;

  logic       busy1, done1, in_ready1, out_valid1, out_last1;
  logic [8:0] out_data1;
  logic [3:0] out_index1;
  logic       busy3, done3, in_ready3, out_valid3, out_last3;
  logic [8:0] out_data3;
  logic [3:0] out_index3;

  logic       start1, start3;
  logic       busy, done, in_ready, out_valid, out_last;
  logic [8:0] out_data;
  logic [3:0] out_index;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign start1    = start & sel;
  assign start3    = start & ~sel;
  assign busy      = sel ? busy1 : busy3;
  assign done      = sel ? done1 : done3;
  assign in_ready  = sel ? in_ready1 : in_ready3;
  assign out_valid = sel ? out_valid1 : out_valid3;
  assign out_last  = sel ? out_last1 : out_last3;
  assign out_data  = sel ? out_data1 : out_data3;
  assign out_index = sel ? out_index1 : out_index3;

  affine2_seq #(.N_OUT(1)) dut1 (
    .clock(clk), .reset(rst_n), .start(start1), .busy(busy1), .done(done1),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_index(out_index1), .out_last(out_last1)
  );

  affine2_seq #(.N_OUT(3)) dut3 (
    .clock(clk), .reset(rst_n), .start(start3), .busy(busy3), .done(done3),
    .in_valid(in_valid), .in_ready(in_ready3), .in_data(in_data),
    .out_valid(out_valid3), .out_ready(out_ready), .out_data(out_data3),
    .out_index(out_index3), .out_last(out_last3)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_first_in_ready"}, int'(in_ready), 1);
    check({tag, "_busy"}, int'(busy), 1);
  endtask

  // Feed 32 words base + n*step; optional idle every other cycle (junk data) and a stray start.
  task automatic feed(input int base, input int step, input bit toggle, input int start_at,
                      input string tag);
    int  n = 0;
    int  cyc = 0;
    bit  acc;
    while (n < 32 && cyc < 200) begin
      if (toggle && cyc[0]) begin
        in_valid = 1'b0;
        in_data  = 9'h1FF;
      end else begin
        in_valid = 1'b1;
        in_data  = 9'(base + n * step);
      end
      start = (cyc == start_at);
      acc = in_valid && in_ready;
      tick();
      if (acc) n++;
      cyc++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (n < 32) check({tag, "_feed_timeout"}, n, 32);
  endtask

  // Called right after the 32nd word edge: one SUM cycle, then the held result.
  task automatic expect_result(input logic [8:0] exp, input int idx, input bit last,
                               input string tag);
    check({tag, "_sum_cycle_valid"}, int'(out_valid), 0);
    check({tag, "_sum_cycle_in_ready"}, int'(in_ready), 0);
    tick();
    check({tag, "_out_valid"}, int'(out_valid), 1);
    check({tag, "_out_data"}, int'(out_data), int'(exp));
    check({tag, "_out_index"}, int'(out_index), idx);
    check({tag, "_out_last"}, int'(out_last), int'(last));
  endtask

  task automatic accept(input bit last, input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_acc_out_valid"}, int'(out_valid), 0);
    check({tag, "_acc_done"}, int'(done), int'(last));
    check({tag, "_acc_busy"}, int'(busy), int'(!last));
    check({tag, "_acc_in_ready"}, int'(in_ready), int'(!last));
    if (last) begin
      tick();
      check({tag, "_done_one_cycle"}, int'(done), 0);
    end
  endtask

  typedef struct {
    int         base;
    int         step;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8,   0,  9'd32};   // 256/8
    vecs[1] = '{511, 0,  9'd508};  // 16352/8 = 2044 -> mod 512
    vecs[2] = '{16,  0,  9'd64};
    vecs[3] = '{0,   0,  9'd0};
    vecs[4] = '{0,   1,  9'd62};   // 496/8
    vecs[5] = '{480, 1,  9'd446};  // 15856/8 = 1982 -> mod 512
    vecs[6] = '{7,   0,  9'd28};   // 224/8
    vecs[7] = '{0,   3,  9'd186};  // 1488/8
    vecs[8] = '{0,   16, 9'd480};  // 7936/8 = 992 -> mod 512
    vecs[9] = '{1,   0,  9'd4};    // 32/8

    repeat (3) tick();
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_index", int'(out_index), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_busy3", int'(busy3), 0);
    rst_n = 1'b1;
    tick();

    // Single-neuron frames over the vector table.
    sel = 1'b1;
    for (int v = 0; v < 10; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      do_start(tag);
      feed(vecs[v].base, vecs[v].step, 1'b0, -1, tag);
      expect_result(vecs[v].exp, 0, 1'b1, tag);
      accept(1'b1, tag);
    end

    // Three-neuron frame with ramps; neuron 1 stalled 10 cycles with junk offered upstream.
    sel = 1'b0;
    do_start("n3");
    for (int j = 0; j < 3; j++) begin
      string tag;
      tag = $sformatf("n3_j%0d", j);
      feed(j, 1, 1'b0, -1, tag);
      expect_result(9'(62 + 4 * j), j, j == 2, tag);
      if (j == 1) begin
        for (int s = 0; s < 10; s++) begin
          in_valid = 1'b1;
          in_data  = 9'h1FF;
          tick();
          check("stall_out_valid", int'(out_valid), 1);
          check("stall_out_data", int'(out_data), 66);
          check("stall_out_index", int'(out_index), 1);
          check("stall_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
      end
      accept(j == 2, tag);
    end

    // Gapped input with a stray start mid-LOAD: 2,4,..,64 -> 1056/8 = 132.
    sel = 1'b1;
    do_start("gap");
    feed(2, 2, 1'b1, 9, "gap");
    expect_result(9'd132, 0, 1'b1, "gap");
    accept(1'b1, "gap");

    // Reset in the middle of a partially loaded bank.
    do_start("rstmid");
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      in_data  = 9'h1FF;
      tick();
    end
    in_valid = 1'b0;
    check("rstmid_busy_before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_in_ready", int'(in_ready), 0);
    check("rstmid_out_valid", int'(out_valid), 0);
    check("rstmid_out_data", int'(out_data), 0);
    check("rstmid_out_index", int'(out_index), 0);
    check("rstmid_out_last", int'(out_last), 0);
    check("rstmid_done", int'(done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rstmid_idle_after", int'(busy), 0);
    do_start("fresh");
    feed(16, 0, 1'b0, -1, "fresh");
    expect_result(9'd64, 0, 1'b1, "fresh");
    accept(1'b1, "fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/affine2_seq.md
# affine2_seq

Sequencer for the affine2 second-stage adder (`affine2_op2`, 32 × 9-bit inputs → 9-bit output). It accepts a serial stream of 9-bit first-stage results, gathers them 32 at a time into a register bank, and fires the shared adder once per bank. It emits one 9-bit result per output neuron over a valid/ready handshake. The block sits between the affine2 first stage and the activation / next-layer logic, and sequences `N_OUT` neurons per frame.

## Interface
- `N_OUT`, default 10: output neurons per frame; legal range 1..16.
- `clock`, input, 1: sole clock, rising edge.
- `reset`, input, 1: asynchronous, active-low; 0 forces reset state.
- `start`, input, 1: one-cycle frame start; honoured only in IDLE.
- `busy`, output, 1: high in any state other than IDLE.
- `done`, output, 1: one-cycle pulse after the last neuron's result is accepted.
- `in_valid`, input, 1: upstream word valid.
- `in_ready`, output, 1: high only in LOAD.
- `in_data`, input, 9: unsigned first-stage word.
- `out_valid`, output, 1: result valid; held until accepted.
- `out_ready`, input, 1: downstream accepts.
- `out_data`, output, 9: scaled sum for the current neuron.
- `out_index`, output, 4: neuron number 0..N_OUT-1 of `out_data`.
- `out_last`, output, 1: high with `out_valid` when `out_index == N_OUT-1`.

## Operation
- **States:** IDLE, LOAD, SUM, OUT.
- **IDLE:**
  - On `start` → LOAD.
  - Neuron counter `nidx` = 0 and word counter `widx` = 0.
- **LOAD:**
  - On each cycle with `in_valid && in_ready`, write `in_data` into bank slot `widx`, then increment `widx`.
  - On the 32nd transfer (`widx == 31`) → SUM, and `widx` wraps to 0.
- **SUM:**
  - Bank slots 0..31 feed the adder ports `data0_in`..`data31_in`.
  - Register the adder's `data_out` into `out_data`.
  - Register `nidx` into `out_index`.
  - → OUT.
- **OUT:**
  - `out_valid` = 1.
  - On `out_ready`, if `nidx == N_OUT-1` → IDLE and pulse `done`; else increment `nidx` → LOAD.
- **Arithmetic:**
  - The sum of 32 unsigned 9-bit words is 14 bits wide.
  - `out_data` = sum[11:3]: divide by 8, then truncate modulo 512. No saturation.
- **`start` while busy:** ignored; it is not queued.
- **`in_valid` outside LOAD:** ignored; `in_ready` = 0 there.
- **Reset, at any time including mid-LOAD or during OUT:**
  - State → IDLE; all counters → 0; bank → 0.
  - `out_data` → 0, `out_index` → 0, `out_valid` → 0, `done` → 0.
  - A partially loaded bank is discarded and is never summed.

## Timing
- **Reset values:** `busy` 0, `done` 0, `in_ready` 0, `out_valid` 0, `out_data` 0, `out_index` 0, `out_last` 0.
- **First word:** `start` sampled at edge t gives LOAD from t+1, so `in_ready` = 1 in cycle t+1.
- **Throughput:** with `in_valid` held high, 32 words take 32 cycles. The last word is accepted at edge k, SUM occupies cycle k+1, and `out_valid` = 1 from cycle k+2.
- **Per-neuron cost:** 32 + 1 + (≥1 OUT) cycles; minimum 34 cycles per neuron.
- **Frame cost:** 34·`N_OUT` cycles at full rate.
- **`done`:** asserted in the cycle after the final OUT handshake, concurrent with IDLE.
- **`out_data` / `out_index`:** stable for the whole time `out_valid` is high.
- **Adder path:** combinational from the bank registers to the SUM capture register; no other path crosses it.
- **Input handshake:** no combinational path from `in_valid` to `in_ready`.
- **Output handshake:** no combinational path from `out_ready` to `out_valid`.

## Structure
- **Shared package `affine2_pkg`:**
  - Constants: `A2_WORD_W` = 9, `A2_FANIN` = 32, `A2_SUM_W` = 14, `A2_SHIFT` = 3.
  - The state enum.
- **Sub-module:** instantiate `affine2_op2` unchanged as the sole sub-module (instance name `op2`).
- **Bank:** a 32 × 9 register array inside the sequencer. No RAM is used, because all 32 words are read in parallel.

## Test plan
- `N_OUT`=1, 32 words all 8, `out_ready` high → `out_data` 32, `out_index` 0, `out_last` 1, `done` pulse one cycle after accept.
- 32 words all 511 → sum 16352; `out_data` = 508 (truncation of bit 12+).
- `N_OUT`=3, neuron j gets ramp 0..31 offset by j (word i = i+j) → `out_data` 62, 66, 70 with `out_index` 0, 1, 2; `done` after third.
- `out_ready` low for 10 cycles in OUT → `out_valid`, `out_data`, `out_index` held; `in_ready` 0; no word consumed; resumes on accept.
- `in_valid` toggled every other cycle plus a second `start` mid-LOAD → exactly 32 accepted transfers per neuron; second `start` has no effect; result matches sum of accepted words only.
- Reset asserted after 17 words → all outputs at reset values immediately; a fresh `start` with 32 words of 16 yields `out_data` 64 (stale words not included).
